// File: rtl/exec_pkg.sv
// exec_pkg: shared encodings for the decode/execute core.
// Opcode and condition enums, instruction class codes, ALUCtl_code bit
// positions, NZCV flag indices and the condition-evaluation helper.
package exec_pkg;

    // Data-processing opcodes, instr[24:21]
    typedef enum logic [3:0] {
        OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3,
        OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7,
        OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB,
        OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF
    } opcode_e;

    // Instruction class as reported in ALUCtl_code[5:4]
    typedef enum logic [1:0] {
        CLS_DP  = 2'b00,
        CLS_DT  = 2'b01,
        CLS_BR  = 2'b10,
        CLS_UND = 2'b11
    } iclass_e;

    // Condition field, instr[31:28]
    typedef enum logic [3:0] {
        CC_EQ = 4'h0, CC_NE = 4'h1, CC_CS = 4'h2, CC_CC = 4'h3,
        CC_MI = 4'h4, CC_PL = 4'h5, CC_VS = 4'h6, CC_VC = 4'h7,
        CC_HI = 4'h8, CC_LS = 4'h9, CC_GE = 4'hA, CC_LT = 4'hB,
        CC_GT = 4'hC, CC_LE = 4'hD, CC_AL = 4'hE, CC_NV = 4'hF
    } cond_e;

    // ALUCtl_code bit positions
    localparam int CTL_OPC_LSB = 0;
    localparam int CTL_CLS_LSB = 4;
    localparam int CTL_IMM     = 6;
    localparam int CTL_SET     = 7;
    localparam int CTL_LINK    = 8;
    localparam int CTL_LOAD    = 9;
    localparam int CTL_EXEC    = 10;

    // Index of each flag inside the 4-bit NZCV vector
    localparam int FLG_N = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    // True when the condition holds for the given NZCV; NV never executes
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v, p;
        n = nzcv[FLG_N];
        z = nzcv[FLG_Z];
        c = nzcv[FLG_C];
        v = nzcv[FLG_V];
        case (cond_e'(cond))
            CC_EQ:   p = z;
            CC_NE:   p = !z;
            CC_CS:   p = c;
            CC_CC:   p = !c;
            CC_MI:   p = n;
            CC_PL:   p = !n;
            CC_VS:   p = v;
            CC_VC:   p = !v;
            CC_HI:   p = c && !z;
            CC_LS:   p = !c || z;
            CC_GE:   p = (n == v);
            CC_LT:   p = (n != v);
            CC_GT:   p = !z && (n == v);
            CC_LE:   p = z || (n != v);
            CC_AL:   p = 1'b1;
            default: p = 1'b0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/exec_alu.sv
// exec_alu: combinational operand2 shifter, 16-op data-processing ALU and
// NZCV generation. Computes B op Operand2; logical ops pass C and V through.
module exec_alu
    import exec_pkg::*;
(
    input  logic [3:0]  i_opcode,
    input  logic        i_imm_en,
    input  logic [11:0] i_op2_field,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_c,
    input  logic        i_v,
    output logic [31:0] o_result,
    output logic [3:0]  o_nzcv
);

    logic [31:0] w_imm32;
    logic [4:0]  w_rot_amt;
    logic [63:0] w_imm_rr;
    logic [4:0]  w_sh_amt;
    logic [63:0] w_a_rr;
    logic [31:0] w_shifted;
    logic [31:0] w_op2;

    logic        w_logic_op;
    logic [31:0] w_logic_res;
    logic [31:0] w_x;
    logic [31:0] w_y;
    logic        w_inv;
    logic        w_cin;
    logic [31:0] w_yy;
    logic [32:0] w_sum;
    logic        w_ovf;

    // Rotations are done by shifting a doubled copy of the value; amount 0
    // naturally yields the value unchanged.
    assign w_imm32   = {24'd0, i_op2_field[7:0]};
    assign w_rot_amt = {i_op2_field[11:8], 1'b0};
    assign w_imm_rr  = {w_imm32, w_imm32} >> w_rot_amt;
    assign w_sh_amt  = i_op2_field[11:7];
    assign w_a_rr    = {i_a, i_a} >> w_sh_amt;

    // Register-operand shifter; instr[4] is not decoded, so only immediate
    // shift amounts exist and an amount of 0 leaves A untouched.
    always_comb begin
        case (i_op2_field[6:5])
            2'b00:   w_shifted = i_a << w_sh_amt;
            2'b01:   w_shifted = i_a >> w_sh_amt;
            2'b10:   w_shifted = $signed(i_a) >>> w_sh_amt;
            default: w_shifted = w_a_rr[31:0];
        endcase
    end

    assign w_op2 = i_imm_en ? w_imm_rr[31:0] : w_shifted;

    // Opcode decode: pick logic result or adder operands (x + ~y + cin for
    // subtracts so the carry-out is the ARM not-borrow).
    always_comb begin
        w_logic_op  = 1'b0;
        w_logic_res = 32'd0;
        w_x         = i_b;
        w_y         = w_op2;
        w_inv       = 1'b0;
        w_cin       = 1'b0;
        case (opcode_e'(i_opcode))
            OP_AND, OP_TST: begin w_logic_op = 1'b1; w_logic_res = i_b & w_op2;  end
            OP_EOR, OP_TEQ: begin w_logic_op = 1'b1; w_logic_res = i_b ^ w_op2;  end
            OP_ORR:         begin w_logic_op = 1'b1; w_logic_res = i_b | w_op2;  end
            OP_MOV:         begin w_logic_op = 1'b1; w_logic_res = w_op2;        end
            OP_BIC:         begin w_logic_op = 1'b1; w_logic_res = i_b & ~w_op2; end
            OP_MVN:         begin w_logic_op = 1'b1; w_logic_res = ~w_op2;       end
            OP_SUB, OP_CMP: begin w_inv = 1'b1; w_cin = 1'b1; end
            OP_RSB:         begin w_x = w_op2; w_y = i_b; w_inv = 1'b1; w_cin = 1'b1; end
            OP_ADD, OP_CMN: begin w_cin = 1'b0; end
            OP_ADC:         begin w_cin = i_c; end
            OP_SBC:         begin w_inv = 1'b1; w_cin = i_c; end
            OP_RSC:         begin w_x = w_op2; w_y = i_b; w_inv = 1'b1; w_cin = i_c; end
            default:        begin w_cin = 1'b0; end
        endcase
    end

    assign w_yy  = w_inv ? ~w_y : w_y;
    assign w_sum = {1'b0, w_x} + {1'b0, w_yy} + {32'd0, w_cin};
    // Signed overflow: both adder inputs agree in sign but the sum does not
    assign w_ovf = (w_x[31] == w_yy[31]) && (w_sum[31] != w_x[31]);

    // Final result and flag vector
    always_comb begin
        o_result       = w_logic_op ? w_logic_res : w_sum[31:0];
        o_nzcv[FLG_N]  = o_result[31];
        o_nzcv[FLG_Z]  = (o_result == 32'd0);
        o_nzcv[FLG_C]  = w_logic_op ? i_c : w_sum[32];
        o_nzcv[FLG_V]  = w_logic_op ? i_v : w_ovf;
    end

endmodule

// File: rtl/exec_decode_core.sv
// exec_decode_core: instruction register, field split, condition check,
// ALU/address/branch-target result, NZCV register and next-PC/link values.
// Optional feature macro: EXEC_BL_LINK_EN (branch-with-link support). When
// undefined, BL executes as a plain B and link_we stays 0.
module exec_decode_core
    import exec_pkg::*;
#(
    parameter logic [31:0] PC_STEP        = 32'd4,
    parameter logic [31:0] PC_PIPE_OFFSET = 32'd8
)
(
    input  logic        clk,
    input  logic        nreset,
    input  logic        enable,
    input  logic        commit,
    input  logic [31:0] instruction_set,
    input  logic [31:0] pc,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [3:0]  rm,
    output logic [3:0]  rn,
    output logic [3:0]  rd,
    output logic [7:0]  shift,
    output logic [3:0]  rotate,
    output logic [7:0]  immediateValue,
    output logic [3:0]  cond_field,
    output logic [11:0] dt_address,
    output logic [23:0] br_address,
    output logic [10:0] ALUCtl_code,
    output logic        execute_flag,
    output logic        cpsr_enable,
    output logic [31:0] cpsr,
    output logic [31:0] ALUOut,
    output logic [31:0] program_counter_next,
    output logic [31:0] next_r14,
    output logic        link_we
);

    logic [31:0] r_instr;
    logic [3:0]  r_nzcv;

    iclass_e     w_class;
    logic [3:0]  w_opcode;
    logic        w_imm_en;
    logic        w_set;
    logic        w_load;
    logic        w_link;
    logic        w_is_cmp;
    logic        w_is_br;
    logic [31:0] w_alu_res;
    logic [3:0]  w_alu_nzcv;
    logic [31:0] w_br_off;
    logic [31:0] w_br_target;
    logic [31:0] w_seq_pc;
    logic [31:0] w_dt_off;

    // Instruction register: load the fetched word when the sequencer enables it
    always_ff @(posedge clk or posedge nreset) begin
        if (nreset)
            r_instr <= 32'd0;
        else if (enable)
            r_instr <= instruction_set;
    end

    // NZCV: written only on a commit strobe of a flag-setting instruction;
    // uses the pre-edge instruction even when enable loads a new one
    always_ff @(posedge clk or posedge nreset) begin
        if (nreset)
            r_nzcv <= 4'd0;
        else if (commit && cpsr_enable)
            r_nzcv <= w_alu_nzcv;
    end

    // Raw field split
    assign rm             = r_instr[3:0];
    assign rn             = r_instr[19:16];
    assign rd             = r_instr[15:12];
    assign shift          = r_instr[11:4];
    assign rotate         = r_instr[11:8];
    assign immediateValue = r_instr[7:0];
    assign cond_field     = r_instr[31:28];
    assign dt_address     = r_instr[11:0];
    assign br_address     = r_instr[23:0];

    assign w_opcode = r_instr[24:21];
    assign w_imm_en = r_instr[25];
    assign w_set    = r_instr[20];
    assign w_load   = r_instr[20];

`ifdef EXEC_BL_LINK_EN
    assign w_link = r_instr[24];
`else
    assign w_link = 1'b0;
`endif

    // Class decode; 10 without bit 25 and 11 are both undefined
    always_comb begin
        case (r_instr[27:26])
            2'b00:   w_class = CLS_DP;
            2'b01:   w_class = CLS_DT;
            2'b10:   w_class = r_instr[25] ? CLS_BR : CLS_UND;
            default: w_class = CLS_UND;
        endcase
    end

    // Undefined instructions never execute regardless of condition
    assign execute_flag = cond_pass(r_instr[31:28], r_nzcv) && (w_class != CLS_UND);

    // TST/TEQ/CMP/CMN always write flags even with S clear
    assign w_is_cmp    = (w_opcode[3:2] == 2'b10);
    assign cpsr_enable = (w_class == CLS_DP) && (w_set || w_is_cmp) && execute_flag;

    assign ALUCtl_code = {execute_flag, w_load, w_link, w_set, w_imm_en, w_class, w_opcode};

    exec_alu u_alu (
        .i_opcode    (w_opcode),
        .i_imm_en    (w_imm_en),
        .i_op2_field (r_instr[11:0]),
        .i_a         (A),
        .i_b         (B),
        .i_c         (r_nzcv[FLG_C]),
        .i_v         (r_nzcv[FLG_V]),
        .o_result    (w_alu_res),
        .o_nzcv      (w_alu_nzcv)
    );

    // Branch target: pipeline offset plus word-scaled signed 24-bit offset
    assign w_br_off    = {{6{r_instr[23]}}, r_instr[23:0], 2'b00};
    assign w_br_target = pc + PC_PIPE_OFFSET + w_br_off;
    assign w_seq_pc    = pc + PC_STEP;
    assign w_dt_off    = {20'd0, r_instr[11:0]};
    assign w_is_br     = (w_class == CLS_BR);

    // Result mux by class: DP result, load/store address, or branch target
    always_comb begin
        case (w_class)
            CLS_DP:  ALUOut = w_alu_res;
            CLS_DT:  ALUOut = r_instr[23] ? (B + w_dt_off) : (B - w_dt_off);
            CLS_BR:  ALUOut = w_br_target;
            default: ALUOut = 32'd0;
        endcase
    end

    assign program_counter_next = (w_is_br && execute_flag) ? w_br_target : w_seq_pc;
    assign next_r14             = w_seq_pc;
    assign link_we              = w_is_br && w_link && execute_flag;
    assign cpsr                 = {r_nzcv, 28'd0};

endmodule

// File: tb/tb_exec_decode_core.sv
// Bench for exec_decode_core: directed steps followed by randomized
// instructions, all checked against a behavioural model of the instruction
// semantics (wide integer arithmetic for carries/overflow).
module tb_exec_decode_core;

    logic        clk;
    logic        nreset;
    logic        enable;
    logic        commit;
    logic [31:0] instruction_set;
    logic [31:0] pc;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  rm, rn, rd, rotate, cond_field;
    logic [7:0]  shift, immediateValue;
    logic [11:0] dt_address;
    logic [23:0] br_address;
    logic [10:0] ALUCtl_code;
    logic        execute_flag, cpsr_enable, link_we;
    logic [31:0] cpsr, ALUOut, program_counter_next, next_r14;

    int total = 0;
    int fails = 0;

    // Model state: architectural instruction register and flags
    logic [31:0] m_instr;
    logic [3:0]  m_flags;

    exec_decode_core dut (
        .clk(clk), .nreset(nreset), .enable(enable), .commit(commit),
        .instruction_set(instruction_set), .pc(pc), .A(A), .B(B),
        .rm(rm), .rn(rn), .rd(rd), .shift(shift), .rotate(rotate),
        .immediateValue(immediateValue), .cond_field(cond_field),
        .dt_address(dt_address), .br_address(br_address),
        .ALUCtl_code(ALUCtl_code), .execute_flag(execute_flag),
        .cpsr_enable(cpsr_enable), .cpsr(cpsr), .ALUOut(ALUOut),
        .program_counter_next(program_counter_next), .next_r14(next_r14),
        .link_we(link_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] alu;
        logic        alu_valid;
        logic [31:0] pcn;
        logic        exe;
        logic        cen;
        logic [3:0]  nzcv;
        logic [10:0] ctl;
        logic        lwe;
    } exp_t;

    function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
        logic [31:0] y;
        y = x;
        for (int i = 0; i < n; i++) y = {y[0], y[31:1]};
        return y;
    endfunction

    function automatic void addm(input logic [31:0] x, input logic [31:0] y, input int ci,
                                 output logic [31:0] r, output logic co, output logic vo);
        longint s, sv;
        s  = longint'(x) + longint'(y) + longint'(ci);
        sv = longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
        r  = s[31:0];
        co = (s > 64'sh0000_0000_FFFF_FFFF);
        vo = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
    endfunction

    function automatic void subm(input logic [31:0] x, input logic [31:0] y, input int bo,
                                 output logic [31:0] r, output logic co, output logic vo);
        longint d, sd;
        d  = longint'(x) - longint'(y) - longint'(bo);
        sd = longint'($signed(x)) - longint'($signed(y)) - longint'(bo);
        r  = d[31:0];
        co = (d >= 0);
        vo = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
    endfunction

    function automatic exp_t model(input logic [31:0] ins, input logic [3:0] f,
                                   input logic [31:0] pcv, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int cls, cin_i, bor_i;
        logic n, z, c, v, pass, lnk, nc, nv;
        logic [3:0] opc;
        logic [4:0] amt;
        logic [31:0] op2, r, tgt;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        if (ins[27:26] == 2'b00)                  cls = 0;
        else if (ins[27:26] == 2'b01)             cls = 1;
        else if (ins[27:26] == 2'b10 && ins[25])  cls = 2;
        else                                      cls = 3;
        case (ins[31:28])
            4'd0: pass = z;        4'd1: pass = !z;
            4'd2: pass = c;        4'd3: pass = !c;
            4'd4: pass = n;        4'd5: pass = !n;
            4'd6: pass = v;        4'd7: pass = !v;
            4'd8: pass = c && !z;  4'd9: pass = !c || z;
            4'd10: pass = n == v;  4'd11: pass = n != v;
            4'd12: pass = !z && n == v;
            4'd13: pass = z || n != v;
            4'd14: pass = 1'b1;
            default: pass = 1'b0;
        endcase
        e = '0;
        e.exe = pass && (cls != 3);
        opc = ins[24:21];
        amt = ins[11:7];
        if (ins[25]) op2 = ror32({24'd0, ins[7:0]}, 2 * int'(ins[11:8]));
        else begin
            case (ins[6:5])
                2'b00:   op2 = a << amt;
                2'b01:   op2 = a >> amt;
                2'b10:   op2 = 32'($signed(a) >>> amt);
                default: op2 = ror32(a, int'(amt));
            endcase
        end
        cin_i = c ? 1 : 0;
        bor_i = c ? 0 : 1;
        nc = c; nv = v; r = 32'd0;
        case (opc)
            4'd0, 4'd8:  r = b & op2;
            4'd1, 4'd9:  r = b ^ op2;
            4'd12:       r = b | op2;
            4'd13:       r = op2;
            4'd14:       r = b & ~op2;
            4'd15:       r = ~op2;
            4'd2, 4'd10: subm(b, op2, 0, r, nc, nv);
            4'd3:        subm(op2, b, 0, r, nc, nv);
            4'd4, 4'd11: addm(b, op2, 0, r, nc, nv);
            4'd5:        addm(b, op2, cin_i, r, nc, nv);
            4'd6:        subm(b, op2, bor_i, r, nc, nv);
            default:     subm(op2, b, bor_i, r, nc, nv);
        endcase
        e.nzcv = {r[31], (r == 32'd0), nc, nv};
        e.cen  = (cls == 0) && (ins[20] || (opc >= 4'd8 && opc <= 4'd11)) && e.exe;
        tgt = 32'(longint'(pcv) + 8 + longint'($signed(ins[23:0])) * 4);
        case (cls)
            0:       e.alu = r;
            1:       e.alu = ins[23] ? 32'(longint'(b) + longint'(ins[11:0]))
                                     : 32'(longint'(b) - longint'(ins[11:0]));
            default: e.alu = tgt;
        endcase
        e.alu_valid = (cls != 3);
        e.pcn = (cls == 2 && e.exe) ? tgt : 32'(longint'(pcv) + 4);
`ifdef EXEC_BL_LINK_EN
        lnk = ins[24];
`else
        lnk = 1'b0;
`endif
        e.ctl = {e.exe, ins[20], lnk, ins[20], ins[25], 2'(cls), opc};
        e.lwe = (cls == 2) && lnk && e.exe;
        return e;
    endfunction

    task automatic chk(input string tg, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: got %h, want %h", tg, obs, expv);
        end
    endtask

    // Compare every output against the model for the current state/inputs
    task automatic check_all(input string tg);
        exp_t e;
        e = model(m_instr, m_flags, pc, A, B);
        chk({tg, ".regs"}, {16'd0, rm, rn, rd, cond_field},
            {16'd0, m_instr[3:0], m_instr[19:16], m_instr[15:12], m_instr[31:28]});
        chk({tg, ".shimm"}, {12'd0, shift, rotate, immediateValue},
            {12'd0, m_instr[11:4], m_instr[11:8], m_instr[7:0]});
        chk({tg, ".dt"}, {20'd0, dt_address}, {20'd0, m_instr[11:0]});
        chk({tg, ".br"}, {8'd0, br_address}, {8'd0, m_instr[23:0]});
        chk({tg, ".ctl"}, {21'd0, ALUCtl_code}, {21'd0, e.ctl});
        chk({tg, ".exe"}, {31'd0, execute_flag}, {31'd0, e.exe});
        chk({tg, ".cen"}, {31'd0, cpsr_enable}, {31'd0, e.cen});
        chk({tg, ".cpsr"}, cpsr, {m_flags, 28'd0});
        if (e.alu_valid) chk({tg, ".alu"}, ALUOut, e.alu);
        chk({tg, ".pcn"}, program_counter_next, e.pcn);
        chk({tg, ".r14"}, next_r14, 32'(longint'(pc) + 4));
        chk({tg, ".lwe"}, {31'd0, link_we}, {31'd0, e.lwe});
    endtask

    // One clock: apply enable/commit, advance the model, check after the edge
    task automatic cycle(input logic en, input logic cm, input string tg);
        exp_t e;
        enable = en;
        commit = cm;
        e = model(m_instr, m_flags, pc, A, B);
        @(posedge clk);
        if (cm && e.cen) m_flags = e.nzcv;
        if (en) m_instr = instruction_set;
        #1;
        enable = 1'b0;
        commit = 1'b0;
        check_all(tg);
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] ins;
        nreset = 1'b1; enable = 1'b0; commit = 1'b0;
        instruction_set = 32'd0; pc = 32'h40; A = 32'd0; B = 32'd0;
        m_instr = 32'd0; m_flags = 4'd0;

        // Reset state
        #3;
        chk("rst.exe", {31'd0, execute_flag}, 32'd0);
        chk("rst.pcn", program_counter_next, 32'h44);
        chk("rst.cpsr", cpsr, 32'd0);
        check_all("rst");
        @(negedge clk);
        nreset = 1'b0;

        // ADD r2,r1,#5
        instruction_set = 32'hE281_2005; B = 32'd10; pc = 32'h80;
        cycle(1'b1, 1'b0, "add");
        chk("add.alu", ALUOut, 32'd15);
        chk("add.rd", {28'd0, rd}, 32'd2);
        chk("add.ctl", {21'd0, ALUCtl_code}, 32'h444);
        chk("add.pcn", program_counter_next, 32'h84);

        // SUBS r3,r1,r1 then commit
        instruction_set = 32'hE051_3001; A = 32'd7; B = 32'd7;
        cycle(1'b1, 1'b0, "subs");
        chk("subs.alu", ALUOut, 32'd0);
        cycle(1'b0, 1'b1, "subs.c");
        chk("subs.cpsr", cpsr, 32'h6000_0000);

        // BEQ +2 taken (Z=1)
        instruction_set = 32'h0A00_0002; pc = 32'h100;
        cycle(1'b1, 1'b0, "beq1");
        chk("beq1.pcn", program_counter_next, 32'h110);

        // CMP r1,r0 then commit
        instruction_set = 32'hE151_0000; A = 32'd5; B = 32'd3;
        cycle(1'b1, 1'b0, "cmp");
        chk("cmp.cen", {31'd0, cpsr_enable}, 32'd1);
        cycle(1'b0, 1'b1, "cmp.c");
        chk("cmp.cpsr", cpsr, 32'h8000_0000);

        // BEQ +2 not taken (Z=0)
        instruction_set = 32'h0A00_0002; pc = 32'h100;
        cycle(1'b1, 1'b0, "beq0");
        chk("beq0.pcn", program_counter_next, 32'h104);
        chk("beq0.exe", {31'd0, execute_flag}, 32'd0);

        // BL -2
        instruction_set = 32'hEBFF_FFFE; pc = 32'h20;
        cycle(1'b1, 1'b0, "bl");
        chk("bl.pcn", program_counter_next, 32'h20);
        chk("bl.r14", next_r14, 32'h24);
`ifdef EXEC_BL_LINK_EN
        chk("bl.lwe", {31'd0, link_we}, 32'd1);
`else
        chk("bl.lwe", {31'd0, link_we}, 32'd0);
`endif

        // Randomized instructions, operands, enable/commit combinations
        for (int it = 0; it < 400; it++) begin
            ins = $urandom;
            case ($urandom_range(0, 3))
                0: ins[27:26] = 2'b00;
                1: ins[27:26] = 2'b01;
                2: begin ins[27:26] = 2'b10; ins[25] = ($urandom_range(0, 4) != 0); end
                default: ins[27:26] = 2'b11;
            endcase
            if ($urandom_range(0, 2) == 0) ins[31:28] = 4'hE;
            instruction_set = ins;
            A = pick_val();
            B = pick_val();
            pc = $urandom & 32'hFFFF_FFFC;
            cycle(($urandom_range(0, 9) < 7), $urandom_range(0, 1) == 1, "rnd");
            A = pick_val();
            B = pick_val();
            #1;
            check_all("rnd.comb");
        end

        // Reset mid-instruction: asynchronous, no clock edge needed
        instruction_set = 32'hE051_3001; A = 32'd1; B = 32'd9;
        cycle(1'b1, 1'b0, "pre");
        @(negedge clk);
        #2;
        nreset = 1'b1;
        m_instr = 32'd0;
        m_flags = 4'd0;
        #1;
        chk("arst.cpsr", cpsr, 32'd0);
        chk("arst.fields", {rm, rn, rd, cond_field, rotate, immediateValue, 4'd0}, 32'd0);
        check_all("arst");
        nreset = 1'b0;

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule

// File: doc/exec_decode_core.md
Name: exec_decode_core

Overview:
- Decode/execute core of the multi-cycle ARM-subset CPU: latches the fetched 32-bit instruction and splits it into register indices and fields.
- Evaluates the condition code against the CPSR flags and computes the ALU result.
- Maintains the NZCV flags and produces the next PC and link value.
- Sits between instruction memory and the register file/memory; the CPU sequencer drives enable/commit.

Parameters:
PC_STEP, 4, sequential PC increment
PC_PIPE_OFFSET, 8, ARM pipeline offset added to branch targets

Ports:
clk  in  1  system clock
nreset  in  1  asynchronous, active-high reset (asserted when 1)
enable  in  1  capture instruction_set into instruction register on clk
commit  in  1  one-cycle strobe; CPSR updates only when high
instruction_set  in  32  fetched instruction
pc  in  32  current program counter
A  in  32  register data for rm (Rm)
B  in  32  register data for rn (Rn)
rm, rn, rd  out  4 each  instr[3:0], instr[19:16], instr[15:12]
shift  out  8  instr[11:4]
rotate  out  4  instr[11:8]
immediateValue  out  8  instr[7:0]
cond_field  out  4  instr[31:28]
dt_address  out  12  instr[11:0]
br_address  out  24  instr[23:0]
ALUCtl_code  out  11  decoded control word
execute_flag  out  1  condition passed
cpsr_enable  out  1  instruction will write flags
cpsr  out  32  {N,Z,C,V,28'b0}
ALUOut  out  32  ALU result
program_counter_next  out  32  next PC
next_r14  out  32  link value
link_we  out  1  write next_r14 into R14

Behaviour:
- Reset (async, nreset=1): instruction register=0 and NZCV=0, so every field output is 0. With EQ and Z=0, execute_flag=0 and program_counter_next=pc+4.
- Instruction register loads on posedge clk when enable=1 and holds otherwise. All outputs are combinational from this register, the flags, pc, A and B.
- Class from instr[27:26]:
  - 00: data processing.
  - 01: load/store.
  - 10 with instr[25]=1: branch.
  - Anything else: undefined; treated as a NOP with execute_flag=0.
- ALUCtl_code:
  - [3:0]=instr[24:21] opcode.
  - [5:4]=class (00 DP, 01 DT, 10 BR, 11 undef).
  - [6]=I bit.
  - [7]=S bit.
  - [8]=branch link (instr[24]).
  - [9]=load (instr[20]).
  - [10]=execute_flag.
- Condition: the 15 standard ARM conditions are evaluated on NZCV; cond 1111 is never-execute.
- Operand2:
  - I=1: immediateValue rotated right by 2*rotate.
  - I=0: A shifted by instr[11:7], type instr[6:5] (LSL/LSR/ASR/ROR). An amount of 0 means no shift.
  - instr[4] is ignored (a shift amount of 0 is used).
- Data processing computes B op Operand2 for all 16 opcodes (AND, EOR, SUB, RSB, ADD, ADC, SBC, RSC, TST, TEQ, CMP, CMN, ORR, MOV, BIC, MVN).
  - ADC/SBC/RSC use C.
  - Arithmetic is modulo 2^32.
  - C = carry-out, and for subtraction C = not-borrow.
  - V = signed overflow.
  - Logical ops leave C and V unchanged.
- cpsr_enable=1 for a DP instruction with (S=1 or opcode TST/TEQ/CMP/CMN) and execute_flag=1. NZCV updates on clk when commit=1 and cpsr_enable=1.
- Load/store: ALUOut = B + dt_address when instr[23]=1, else B - dt_address.
- Branch: ALUOut = target.
- program_counter_next:
  - Taken branch (BR and execute_flag): pc + PC_PIPE_OFFSET + (sign-extended br_address << 2).
  - Otherwise: pc + PC_STEP.
  - Both wrap modulo 2^32.
- next_r14 = pc + PC_STEP always. link_we = BR & link & execute_flag.
- Simultaneous enable and commit: commit uses the flags and instruction from before the edge.

Optional Feature:
- Macro EXEC_BL_LINK_EN.
- Defined: BL is supported as above.
- Undefined: link_we is tied to 0, ALUCtl_code[8]=0, and BL behaves as plain B.

Decomposition:
- Package exec_pkg holds:
  - Opcode constants.
  - Class encodings.
  - Condition codes.
  - ALUCtl_code bit positions.
  - Flag indices.
- One natural sub-module, exec_alu: purely combinational; operand2 shifter, 16-op ALU and NZCV generation.

Test Plan:
- Reset: assert nreset with enable=0 and pc=0x40 -> all fields 0, cpsr=0, execute_flag=0, program_counter_next=0x44.
- ADD r2,r1,#5 (0xE2812005), B=10 -> ALUOut=15, rd=2, ALUCtl_code=0x444, program_counter_next=pc+4.
- SUBS r3,r1,r1 (0xE0513001), A=B=7, then commit -> ALUOut=0, cpsr[31:28]=0110.
- CMP r1,r0 (0xE1510000), A=5, B=3, then commit -> cpsr[31:28]=1000; cpsr_enable=1.
- BEQ +2 (0x0A000002), pc=0x100:
  - Z=1 -> program_counter_next=0x110.
  - Z=0 -> program_counter_next=0x104, execute_flag=0.
- BL -2 (0xEBFFFFFE), pc=0x20 -> program_counter_next=0x20, next_r14=0x24, link_we=1.
- Reset asserted mid-instruction -> cpsr and fields clear immediately, without waiting for clk.
